// File: rtl/issue_dispatch_queue.sv
// ---------------------------------------------------------------------------
// issue_dispatch_queue
//   Splits an in-order instruction bundle into three class queues (LSU, CSR,
//   ALU) and presents the head of each queue to its execution pipe.
//
//   Handshake rule (all interfaces): a transfer happens on a rising clk edge
//   when valid and ready are both high; valid never depends on ready.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid / in_ready      bundle offer / atomic acceptance
//     in_inst                  SLOTS instruction words, slot 0 oldest
//     in_slot_vld              per-slot valid mask
//     in_br_vld / in_br_idx    first branch in bundle; younger slots dropped
//     flush                    synchronous clear of all queues
//     {lsu,csr,alu}_valid/_ready/_inst   head of each class queue
//     {lsu,csr,alu}_count      occupancy of each class queue
//     stall_cnt, drop_cnt      statistics, present only when the macro
//                              ISSUE_DISPATCH_STATS_EN is defined
// ---------------------------------------------------------------------------

// One class queue: multi-write (up to SLOTS per cycle), single read.
module idq_class_fifo #(
   parameter int SLOTS  = 4,
   parameter int DEPTH  = 8,
   parameter int INST_W = 73,
   localparam int AW = $clog2(DEPTH),
   localparam int PW = AW + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush_i,
   input  logic                      enq_i,
   input  logic [SLOTS-1:0]          enq_mask_i,
   input  logic [SLOTS*INST_W-1:0]   enq_inst_i,
   input  logic                      deq_ready_i,
   output logic                      valid_o,
   output logic [INST_W-1:0]         inst_o,
   output logic [PW-1:0]             count_o
);

   logic [INST_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     count;
   logic [AW-1:0]     waddr [SLOTS];
   logic [SLOTS-1:0]  wen;
   logic              deq;

   // Extra pointer bit makes count unambiguous across the full/empty wrap.
   assign count   = wr_ptr_q - rd_ptr_q;
   assign count_o = count;
   assign valid_o = (count != '0);
   assign deq     = valid_o && deq_ready_i;
   // Storage is unreset, so the head is masked while the queue is empty.
   assign inst_o  = valid_o ? mem[rd_ptr_q[AW-1:0]] : '0;

   // Selected slots pack into consecutive entries in ascending slot order.
   always_comb begin
      logic [PW-1:0] off;
      off      = '0;
      wen      = '0;
      for (int i = 0; i < SLOTS; i++) begin
         waddr[i] = '0;
         if (enq_i && enq_mask_i[i]) begin
            wen[i]   = 1'b1;
            waddr[i] = wr_ptr_q[AW-1:0] + off[AW-1:0];
            off      = off + PW'(1);
         end
      end
      wr_ptr_d = wr_ptr_q + off;
      rd_ptr_d = rd_ptr_q;
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < SLOTS; i++) begin
         if (wen[i]) begin
            mem[waddr[i]] <= enq_inst_i[i*INST_W +: INST_W];
         end
      end
   end

endmodule

module issue_dispatch_queue #(
   parameter int SLOTS  = 4,
   parameter int DEPTH  = 8,
   parameter int INST_W = 73,
   localparam int BW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SLOTS*INST_W-1:0] in_inst,
   input  logic [SLOTS-1:0]        in_slot_vld,
   input  logic                    in_br_vld,
   input  logic [BW-1:0]           in_br_idx,
   input  logic                    flush,
   output logic                    lsu_valid,
   input  logic                    lsu_ready,
   output logic [INST_W-1:0]       lsu_inst,
   output logic                    csr_valid,
   input  logic                    csr_ready,
   output logic [INST_W-1:0]       csr_inst,
   output logic                    alu_valid,
   input  logic                    alu_ready,
   output logic [INST_W-1:0]       alu_inst,
   output logic [CW-1:0]           lsu_count,
   output logic [CW-1:0]           csr_count,
   output logic [CW-1:0]           alu_count
`ifdef ISSUE_DISPATCH_STATS_EN
   ,
   output logic [15:0]             stall_cnt,
   output logic [15:0]             drop_cnt
`endif
);

   typedef enum logic [1:0] {CL_LSU, CL_CSR, CL_ALU} cls_e;

   function automatic cls_e classify(input logic [6:0] op);
      if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0101111) begin
         return CL_LSU;
      end else if (op == 7'b1110011) begin
         return CL_CSR;
      end
      return CL_ALU;
   endfunction

   logic [SLOTS-1:0] live;
   logic [SLOTS-1:0] lsu_mask, csr_mask, alu_mask;
   int               lsu_n, csr_n, alu_n;
   logic             fits;
   logic             accept;

   always_comb begin
      live     = '0;
      lsu_mask = '0;
      csr_mask = '0;
      alu_mask = '0;
      lsu_n    = 0;
      csr_n    = 0;
      alu_n    = 0;
      for (int i = 0; i < SLOTS; i++) begin
         live[i] = in_slot_vld[i] && (!in_br_vld || (BW'(i) <= in_br_idx));
         if (live[i]) begin
            case (classify(in_inst[i*INST_W +: 7]))
               CL_LSU: begin
                  lsu_mask[i] = 1'b1;
                  lsu_n++;
               end
               CL_CSR: begin
                  csr_mask[i] = 1'b1;
                  csr_n++;
               end
               default: begin
                  alu_mask[i] = 1'b1;
                  alu_n++;
               end
            endcase
         end
      end
   end

   // Space check uses occupancy before this cycle's dequeue: no credit is
   // taken for a head leaving in the same cycle.
   assign fits = (lsu_n <= DEPTH - int'(lsu_count)) &&
                 (csr_n <= DEPTH - int'(csr_count)) &&
                 (alu_n <= DEPTH - int'(alu_count));

   assign in_ready = !rst && !flush && fits;
   assign accept   = in_valid && in_ready;

   idq_class_fifo #(.SLOTS(SLOTS), .DEPTH(DEPTH), .INST_W(INST_W)) u_lsu (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .enq_i       (accept),
      .enq_mask_i  (lsu_mask),
      .enq_inst_i  (in_inst),
      .deq_ready_i (lsu_ready),
      .valid_o     (lsu_valid),
      .inst_o      (lsu_inst),
      .count_o     (lsu_count)
   );

   idq_class_fifo #(.SLOTS(SLOTS), .DEPTH(DEPTH), .INST_W(INST_W)) u_csr (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .enq_i       (accept),
      .enq_mask_i  (csr_mask),
      .enq_inst_i  (in_inst),
      .deq_ready_i (csr_ready),
      .valid_o     (csr_valid),
      .inst_o      (csr_inst),
      .count_o     (csr_count)
   );

   idq_class_fifo #(.SLOTS(SLOTS), .DEPTH(DEPTH), .INST_W(INST_W)) u_alu (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush),
      .enq_i       (accept),
      .enq_mask_i  (alu_mask),
      .enq_inst_i  (in_inst),
      .deq_ready_i (alu_ready),
      .valid_o     (alu_valid),
      .inst_o      (alu_inst),
      .count_o     (alu_count)
   );

`ifdef ISSUE_DISPATCH_STATS_EN
   logic [15:0] stall_q, stall_d;
   logic [15:0] drop_q, drop_d;
   int          drop_n;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
      logic [16:0] s;
      s = {1'b0, a} + 17'(n);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Valid slots younger than the branch are the ones masked off.
   always_comb begin
      drop_n = 0;
      for (int i = 0; i < SLOTS; i++) begin
         if (in_slot_vld[i] && !live[i]) begin
            drop_n++;
         end
      end
      stall_d = stall_q;
      drop_d  = drop_q;
      if (flush) begin
         stall_d = '0;
         drop_d  = '0;
      end else begin
         if (in_valid && !in_ready) begin
            stall_d = sat_add(stall_q, 1);
         end
         if (accept) begin
            drop_d = sat_add(drop_q, drop_n);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         drop_q  <= '0;
      end else begin
         stall_q <= stall_d;
         drop_q  <= drop_d;
      end
   end

   assign stall_cnt = stall_q;
   assign drop_cnt  = drop_q;
`endif

endmodule
